mvtr_reg: RTL and testbench

- Registered M-way majority voter for TMR-protected N-bit words.
- Takes M redundant copies of a word and drives the bitwise majority value.
- Flags any copy that disagrees with the voted result.
- Sits at the boundary of TMR register groups and flags single-copy upsets to the monitoring logic.

---
 rtl/mvtr_pkg.sv | 18 +
 rtl/mvtr_bit.sv | 29 ++
 rtl/mvtr_reg.sv | 88 ++++++++
 tb/tb_mvtr_reg.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mvtr_pkg.sv
// Shared definitions for the mvtr_reg majority voter.
// Optional feature macro: MVTR_ERRCNT_EN (adds the saturating warn counter).
package mvtr_pkg;

  // Width of the optional warn-cycle counter.
  localparam int ERRCNT_W = 16;

  // Majority decision: strictly more than half of the m copies voted 1.
  function automatic logic maj_bit(input int unsigned count, input int unsigned m);
    return (count > (m / 32'd2));
  endfunction

  // Legal copy counts: odd and at least 3, so a strict majority always exists.
  function automatic bit m_is_valid(input int m);
    return (m >= 32'sd3) && ((m % 32'sd2) == 32'sd1);
  endfunction

endpackage

// File: rtl/mvtr_bit.sv
// Single bit-position voter: majority bit, non-unanimity flag and
// per-copy disagreement vector for the M copies of one bit.
module mvtr_bit
  import mvtr_pkg::*;
#(
  parameter int M = 3
) (
  input  logic [M-1:0] bits,
  output logic         voted,
  output logic         mismatch,
  output logic [M-1:0] differ
);

  localparam int CW = $clog2(M + 1);

  logic [CW-1:0] count_s;

  // Population count of the copies, then majority and disagreement decode.
  always_comb begin
    count_s = {CW{1'b0}};
    for (int k = 0; k < M; k++) begin
      count_s = count_s + {{(CW-1){1'b0}}, bits[k]};
    end
    voted    = maj_bit(32'(count_s), M);
    mismatch = (|bits) & ~(&bits);
    differ   = bits ^ {M{voted}};
  end

endmodule

// File: rtl/mvtr_reg.sv
// Registered M-way bitwise majority voter for TMR-protected N-bit words.
// Copy k of vtr_i lives in bits [k*N+N-1 : k*N]. Outputs follow the
// inputs with exactly one clock of latency.
// Optional feature macro: MVTR_ERRCNT_EN adds err_cnt_o, a 16-bit
// saturating count of clock edges that saw a non-unanimous vote.
module mvtr_reg
  import mvtr_pkg::*;
#(
  parameter int M = 3,
  parameter int N = 8
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [M*N-1:0]      vtr_i,
  output logic [N-1:0]        vtr_o,
  output logic                warn_o,
`ifdef MVTR_ERRCNT_EN
  output logic [M-1:0]        dis_o,
  output logic [ERRCNT_W-1:0] err_cnt_o
`else
  output logic [M-1:0]        dis_o
`endif
);

  // Reject configurations with no strict majority or an empty word.
  if (!m_is_valid(M)) begin : g_bad_m
    $error("mvtr_reg: M must be odd and >= 3");
  end
  if (N < 1) begin : g_bad_n
    $error("mvtr_reg: N must be >= 1");
  end

  logic [N-1:0] voted_s;
  logic [N-1:0] mism_s;
  logic [M-1:0] differ_s [N];
  logic [M-1:0] dis_s;
  logic         warn_s;

  // One voter per bit position, fed with that bit of every copy.
  for (genvar b = 0; b < N; b++) begin : g_bit
    logic [M-1:0] col_s;
    for (genvar k = 0; k < M; k++) begin : g_col
      assign col_s[k] = vtr_i[k*N + b];
    end
    mvtr_bit #(.M(M)) u_bit (
      .bits     (col_s),
      .voted    (voted_s[b]),
      .mismatch (mism_s[b]),
      .differ   (differ_s[b])
    );
  end

  // Fold per-bit disagreement into per-copy flags and the overall warning.
  always_comb begin
    dis_s = {M{1'b0}};
    for (int b = 0; b < N; b++) begin
      dis_s = dis_s | differ_s[b];
    end
    warn_s = |mism_s;
  end

  // Output registers: the vote is re-evaluated and captured every cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vtr_o  <= {N{1'b0}};
      warn_o <= 1'b0;
      dis_o  <= {M{1'b0}};
    end else begin
      vtr_o  <= voted_s;
      warn_o <= warn_s;
      dis_o  <= dis_s;
    end
  end

`ifdef MVTR_ERRCNT_EN
  // Saturating count of edges with a non-unanimous vote; never wraps.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_cnt_o <= 16'h0000;
    end else if (warn_s && (err_cnt_o != 16'hFFFF)) begin
      err_cnt_o <= err_cnt_o + 16'h0001;
    end else begin
      err_cnt_o <= err_cnt_o;
    end
  end
`endif

endmodule

// File: tb/tb_mvtr_reg.sv
// Self-checking bench for mvtr_reg: a 3x32 and a 5x4 instance share the
// clock and reset. Table vectors, hand sequences and randomized stimulus
// are checked against a counting reference model.
module tb_mvtr_reg;

  logic        clk;
  logic        rstn;
  logic [95:0] v3;
  logic [19:0] v5;
  logic [31:0] vt3;
  logic        w3;
  logic [2:0]  d3;
  logic [3:0]  vt5;
  logic        w5;
  logic [4:0]  d5;
`ifdef MVTR_ERRCNT_EN
  logic [15:0] c3;
  logic [15:0] c5;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  mvtr_reg #(.M(3), .N(32)) u3 (
    .clk_i (clk), .rstn_i (rstn), .vtr_i (v3),
    .vtr_o (vt3), .warn_o (w3),
`ifdef MVTR_ERRCNT_EN
    .dis_o (d3), .err_cnt_o (c3)
`else
    .dis_o (d3)
`endif
  );

  mvtr_reg #(.M(5), .N(4)) u5 (
    .clk_i (clk), .rstn_i (rstn), .vtr_i (v5),
    .vtr_o (vt5), .warn_o (w5),
`ifdef MVTR_ERRCNT_EN
    .dis_o (d5), .err_cnt_o (c5)
`else
    .dis_o (d5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] v3;
    logic [31:0] vt3;
    logic        w3;
    logic [2:0]  d3;
    logic [19:0] v5;
    logic [3:0]  vt5;
    logic        w5;
    logic [4:0]  d5;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: count ones per bit, majority if count*2 > m; a copy disagrees
  // when its whole word differs from the voted word.
  function automatic void ref_vote(input int m, input int n, input logic [127:0] v,
                                   output logic [31:0] vt, output logic w,
                                   output logic [4:0] dis);
    logic [127:0] sh;
    logic [31:0]  mask;
    logic [31:0]  cp;
    int           cnt;
    vt   = 32'h0;
    w    = 1'b0;
    dis  = 5'b0;
    mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    for (int b = 0; b < n; b++) begin
      cnt = 0;
      for (int k = 0; k < m; k++) if (v[k*n + b]) cnt++;
      vt[b] = (cnt * 2 > m);
      if (cnt != 0 && cnt != m) w = 1'b1;
    end
    for (int k = 0; k < m; k++) begin
      sh = v >> (k * n);
      cp = sh[31:0] & mask;
      dis[k] = (cp != vt);
    end
  endfunction

  task automatic check_model(input string tag);
    logic [31:0] evt;
    logic        ew;
    logic [4:0]  ed;
    ref_vote(3, 32, {32'h0, v3}, evt, ew, ed);
    ref_vote(5, 4, {108'h0, v5}, evt, ew, ed);
    evt = 32'h0;
  endtask

  logic [31:0] e_vt3, e_vt5;
  logic        e_w3, e_w5;
  logic [4:0]  e_d3, e_d5;
  logic [31:0] base;
  logic [31:0] cp3 [3];
  logic [3:0]  cp5 [5];

  initial begin
    tbl[0] = '{ {32'hFF, 32'hFF, 32'hFF}, 32'hFF, 1'b0, 3'b000,
                {4'hF, 4'hF, 4'hF, 4'h0, 4'h0}, 4'hF, 1'b1, 5'b00011 };
    tbl[1] = '{ {32'h1000, 32'h1100, 32'h0100}, 32'h1100, 1'b1, 3'b101,
                {4'h0, 4'hF, 4'h0, 4'hF, 4'hF}, 4'hF, 1'b1, 5'b10100 };
    tbl[2] = '{ {32'h0, 32'hFF, 32'hFF}, 32'hFF, 1'b1, 3'b100,
                {4'hF, 4'h0, 4'hF, 4'h0, 4'hF}, 4'hF, 1'b1, 5'b01010 };
    tbl[3] = '{ {32'h0, 32'h0, 32'hFF}, 32'h0, 1'b1, 3'b001,
                {4'hF, 4'hF, 4'hF, 4'hF, 4'hF}, 4'hF, 1'b0, 5'b00000 };
    tbl[4] = '{ {32'h6, 32'h5, 32'h3}, 32'h7, 1'b1, 3'b111,
                {4'hA, 4'h5, 4'hA, 4'h5, 4'hA}, 4'hA, 1'b1, 5'b01010 };
    tbl[5] = '{ {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF}, 32'hDEADBEEF, 1'b0, 3'b000,
                {4'h0, 4'h0, 4'h0, 4'hF, 4'hF}, 4'h0, 1'b1, 5'b00011 };

    // Reset holds outputs at zero regardless of clock edges.
    rstn = 1'b0;
    v3   = {3{32'hA5}};
    v5   = {5{4'h5}};
    #1;
    chk("rst_vt3", vt3, 32'h0);
    chk("rst_w3", {31'h0, w3}, 32'h0);
    chk("rst_d3", {29'h0, d3}, 32'h0);
    chk("rst_vt5", {28'h0, vt5}, 32'h0);
    step();
    step();
    chk("rst_hold_vt3", vt3, 32'h0);
    chk("rst_hold_d5", {27'h0, d5}, 32'h0);
`ifdef MVTR_ERRCNT_EN
    chk("rst_cnt3", {16'h0, c3}, 32'h0);
`endif
    #2 rstn = 1'b1;
    step();
    chk("rel_vt3", vt3, 32'hA5);
    chk("rel_w3", {31'h0, w3}, 32'h0);
    chk("rel_vt5", {28'h0, vt5}, 32'h5);

    // Table-driven vectors, one-cycle latency.
    for (int i = 0; i < 6; i++) begin
      v3 = tbl[i].v3;
      v5 = tbl[i].v5;
      step();
      chk($sformatf("tbl%0d_vt3", i), vt3, tbl[i].vt3);
      chk($sformatf("tbl%0d_w3", i), {31'h0, w3}, {31'h0, tbl[i].w3});
      chk($sformatf("tbl%0d_d3", i), {29'h0, d3}, {29'h0, tbl[i].d3});
      chk($sformatf("tbl%0d_vt5", i), {28'h0, vt5}, {28'h0, tbl[i].vt5});
      chk($sformatf("tbl%0d_w5", i), {31'h0, w5}, {31'h0, tbl[i].w5});
      chk($sformatf("tbl%0d_d5", i), {27'h0, d5}, {27'h0, tbl[i].d5});
    end

    // Latency: output must not change before the edge.
    v3 = {3{32'h12345678}};
    #2;
    chk("lat_before_edge", vt3, tbl[5].vt3);
    step();
    chk("lat_after_edge", vt3, 32'h12345678);

    // M=5: any two copies at 0 each cycle keeps the vote at F.
    for (int i = 0; i < 8; i++) begin
      int a, b;
      a = $urandom_range(0, 4);
      b = (a + 1 + $urandom_range(0, 3)) % 5;
      v5 = {5{4'hF}};
      v5[a*4 +: 4] = 4'h0;
      v5[b*4 +: 4] = 4'h0;
      step();
      chk($sformatf("m5_two_zero%0d_vt", i), {28'h0, vt5}, 32'hF);
      chk($sformatf("m5_two_zero%0d_d", i), {27'h0, d5}, (32'h1 << a) | (32'h1 << b));
    end

    // Mid-sequence reset clears outputs without a clock edge.
    #2 rstn = 1'b0;
    #1;
    chk("midrst_vt5", {28'h0, vt5}, 32'h0);
    chk("midrst_d5", {27'h0, d5}, 32'h0);
    chk("midrst_w5", {31'h0, w5}, 32'h0);
    chk("midrst_vt3", vt3, 32'h0);
    #2 rstn = 1'b1;

    // Randomized: near-agreeing copies with occasional upsets.
    for (int i = 0; i < 300; i++) begin
      base = $urandom;
      for (int k = 0; k < 3; k++) begin
        cp3[k] = base;
        if ($urandom_range(0, 2) == 0) cp3[k] = cp3[k] ^ (32'h1 << $urandom_range(0, 31));
        if ($urandom_range(0, 9) == 0) cp3[k] = $urandom;
      end
      for (int k = 0; k < 5; k++) begin
        cp5[k] = base[3:0];
        if ($urandom_range(0, 2) == 0) cp5[k] = 4'($urandom);
      end
      v3 = {cp3[2], cp3[1], cp3[0]};
      v5 = {cp5[4], cp5[3], cp5[2], cp5[1], cp5[0]};
      ref_vote(3, 32, {32'h0, v3}, e_vt3, e_w3, e_d3);
      ref_vote(5, 4, {108'h0, v5}, e_vt5, e_w5, e_d5);
      step();
      chk("rnd_vt3", vt3, e_vt3);
      chk("rnd_w3", {31'h0, w3}, {31'h0, e_w3});
      chk("rnd_d3", {29'h0, d3}, {27'h0, e_d3});
      chk("rnd_vt5", {28'h0, vt5}, e_vt5);
      chk("rnd_w5", {31'h0, w5}, {31'h0, e_w5});
      chk("rnd_d5", {27'h0, d5}, {27'h0, e_d5});
    end

`ifdef MVTR_ERRCNT_EN
    // Counter: fresh reset, 5 mismatching cycles, then saturation.
    #2 rstn = 1'b0;
    #1;
    chk("cnt_rst", {16'h0, c3}, 32'h0);
    v3 = {32'h1, 32'h0, 32'h0};
    v5 = {4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    #1 rstn = 1'b1;
    repeat (5) step();
    chk("cnt5_u3", {16'h0, c3}, 32'd5);
    chk("cnt5_u5", {16'h0, c5}, 32'd5);
    v3 = {3{32'h77}};
    step();
    chk("cnt_hold", {16'h0, c3}, 32'd5);
    v3 = {32'h1, 32'h0, 32'h0};
    repeat (65529) step();
    chk("cnt_fffe", {16'h0, c3}, 32'h0000FFFE);
    step();
    chk("cnt_ffff", {16'h0, c3}, 32'h0000FFFF);
    repeat (3) step();
    chk("cnt_sat", {16'h0, c3}, 32'h0000FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
